// File: rtl/psl_pkg.sv
// Shared definitions for the host write path around the PSL buffer.
// Provides the default item geometry and the item-count type carried on
// num_items_per_data.
package psl_pkg;

  localparam int unsigned ITEM_W         = 512;
  localparam int unsigned ITEMS_PER_WORD = 4;
  localparam int unsigned CNT_W          = 6;

  // Item count: lanes filled in the assembly register and lanes valid in an output word.
  typedef logic [CNT_W-1:0] item_cnt_t;

endpackage

// File: rtl/packer_out_reg.sv
// Output holding register of result_packer.
// Holds one packed word with a valid/ready handshake toward the PSL buffer,
// pulses num_valid_o on the first cycle of each newly loaded word and keeps
// the running count of items transferred out.
//
// Ports:
//   clk, rstb        clock, asynchronous active-low reset
//   load_i           load word_i/cnt_i this cycle (only when free_o is high)
//   word_i, cnt_i    packed word and its valid-lane count
//   read_data_i      consumer ready
//   free_o           register empty or being drained this cycle
//   data_o           held word
//   data_valid_o     word held until consumed
//   num_o            valid lanes in data_o
//   num_valid_o      one-cycle pulse on a newly loaded word
//   items_emitted_o  running count of items transferred out, wraps at 2^32
module packer_out_reg
  import psl_pkg::*;
#(
  parameter int unsigned WordW = psl_pkg::ITEM_W * psl_pkg::ITEMS_PER_WORD
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             load_i,
  input  logic [WordW-1:0] word_i,
  input  item_cnt_t        cnt_i,
  input  logic             read_data_i,
  output logic             free_o,
  output logic [WordW-1:0] data_o,
  output logic             data_valid_o,
  output item_cnt_t        num_o,
  output logic             num_valid_o,
  output logic [31:0]      items_emitted_o
);

  logic [WordW-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  item_cnt_t        num_q, num_d;
  logic             num_valid_q, num_valid_d;
  logic [31:0]      emitted_q, emitted_d;
  logic             xfer;

  always_comb begin
    xfer        = valid_q & read_data_i;
    free_o      = ~valid_q | xfer;
    data_d      = data_q;
    num_d       = num_q;
    valid_d     = valid_q;
    num_valid_d = load_i;
    emitted_d   = emitted_q;
    if (xfer) begin
      valid_d   = 1'b0;
      emitted_d = emitted_q + 32'(num_q);
    end
    // A load in the same cycle as a transfer replaces the departing word.
    if (load_i) begin
      data_d  = word_i;
      num_d   = cnt_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      num_q       <= '0;
      num_valid_q <= 1'b0;
      emitted_q   <= '0;
    end else begin
      data_q      <= data_d;
      valid_q     <= valid_d;
      num_q       <= num_d;
      num_valid_q <= num_valid_d;
      emitted_q   <= emitted_d;
    end
  end

  assign data_o          = data_q;
  assign data_valid_o    = valid_q;
  assign num_o           = num_q;
  assign num_valid_o     = num_valid_q;
  assign items_emitted_o = emitted_q;

endmodule

// File: rtl/result_packer.sv
// result_packer: packs corrected-read items into wide words for the PSL buffer.
// Items fill an assembly register lane by lane (first item in lane 0); a full
// or flushed assembly is promoted into packer_out_reg, which presents it on
// data / num_items_per_data until the consumer takes it.
//
// Ports:
//   clk, rstb                  clock, asynchronous active-low reset
//   item_data/valid/ready      item input handshake
//   flush, flush_done          flush request and its completion pulse
//   data, data_valid, read_data  output word handshake
//   num_items_per_data(_valid) valid lanes of data, pulse on each new word
//   items_emitted              running count of items transferred out
//
// Build option: define RESULT_PACKER_TIMEOUT_EN to add an idle counter that
// auto-flushes a partial word after TIMEOUT idle cycles (no flush_done pulse).
module result_packer
  import psl_pkg::*;
#(
  parameter int unsigned ITEM_W         = psl_pkg::ITEM_W,
  parameter int unsigned ITEMS_PER_WORD = psl_pkg::ITEMS_PER_WORD,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic                             clk,
  input  logic                             rstb,
  input  logic [ITEM_W-1:0]                item_data,
  input  logic                             item_valid,
  output logic                             item_ready,
  input  logic                             flush,
  output logic                             flush_done,
  output logic [ITEM_W*ITEMS_PER_WORD-1:0] data,
  output logic                             data_valid,
  input  logic                             read_data,
  output item_cnt_t                        num_items_per_data,
  output logic                             num_items_per_data_valid,
  output logic [31:0]                      items_emitted
);

  localparam int unsigned WordW   = ITEM_W * ITEMS_PER_WORD;
  localparam item_cnt_t   FullCnt = item_cnt_t'(ITEMS_PER_WORD);

  logic [ITEMS_PER_WORD-1:0][ITEM_W-1:0] asm_q, asm_d;
  logic [ITEMS_PER_WORD-1:0][ITEM_W-1:0] word;
  item_cnt_t cnt_q, cnt_d;
  logic      flush_pending_q, flush_pending_d;

  logic      accept;
  item_cnt_t fill;
  logic      incl;
  item_cnt_t word_cnt;
  logic      flush_req;
  logic      trigger;
  logic      promote;
  logic      out_free;
  logic      auto_flush;

  always_comb begin
    item_ready = (cnt_q < FullCnt);
    accept     = item_valid & item_ready;
    fill       = cnt_q + item_cnt_t'(accept);
    // The accepted item joins the promoted word when it completes the word
    // or arrives together with the flush request.
    incl       = accept & ((fill == FullCnt) | flush);
    word_cnt   = incl ? fill : cnt_q;
    flush_req  = flush_pending_q | flush | auto_flush;
    trigger    = (word_cnt == FullCnt) | (flush_req & (word_cnt != '0));
    promote    = trigger & out_free;

    // Lanes at or above the word count are zeroed.
    for (int k = 0; k < ITEMS_PER_WORD; k++) begin
      if (item_cnt_t'(k) < cnt_q) begin
        word[k] = asm_q[k];
      end else if (incl && (item_cnt_t'(k) == cnt_q)) begin
        word[k] = item_data;
      end else begin
        word[k] = '0;
      end
    end

    asm_d = asm_q;
    cnt_d = cnt_q;
    if (promote) begin
      if (accept && !incl) begin
        asm_d[0] = item_data;
        cnt_d    = item_cnt_t'(1);
      end else begin
        cnt_d = '0;
      end
    end else if (accept) begin
      for (int k = 0; k < ITEMS_PER_WORD; k++) begin
        if (item_cnt_t'(k) == cnt_q) begin
          asm_d[k] = item_data;
        end
      end
      cnt_d = fill;
    end

    // Done once both stages are empty and nothing new entered this cycle.
    flush_done      = flush_pending_q & (cnt_q == '0) & ~data_valid & ~accept;
    flush_pending_d = flush | (flush_pending_q & ~flush_done);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      asm_q           <= '0;
      cnt_q           <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      asm_q           <= asm_d;
      cnt_q           <= cnt_d;
      flush_pending_q <= flush_pending_d;
    end
  end

`ifdef RESULT_PACKER_TIMEOUT_EN
  localparam int unsigned IdleW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT);

  logic [IdleW-1:0] idle_q, idle_d;

  // Saturates at TIMEOUT so the auto-flush request holds until promotion.
  always_comb begin
    idle_d = idle_q;
    if (accept || promote) begin
      idle_d = '0;
    end else if ((cnt_q != '0) && (idle_q != IdleMax)) begin
      idle_d = idle_q + 1'b1;
    end
    auto_flush = (cnt_q != '0) & (idle_q == IdleMax);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  // Without the idle counter TIMEOUT has no effect.
  assign auto_flush = 1'b0 & (TIMEOUT != 0);
`endif

  packer_out_reg #(
    .WordW (WordW)
  ) u_out (
    .clk             (clk),
    .rstb            (rstb),
    .load_i          (promote),
    .word_i          (word),
    .cnt_i           (word_cnt),
    .read_data_i     (read_data),
    .free_o          (out_free),
    .data_o          (data),
    .data_valid_o    (data_valid),
    .num_o           (num_items_per_data),
    .num_valid_o     (num_items_per_data_valid),
    .items_emitted_o (items_emitted)
  );

endmodule

// File: tb/tb_result_packer.sv
// Self-checking bench for result_packer: directed scenarios with literal
// expectations plus a transaction-level packing model checked on every cycle.
module tb_result_packer;
  import psl_pkg::*;

  localparam int IW = 512;
  localparam int NL = 4;
  localparam int WW = IW * NL;
`ifdef RESULT_PACKER_TIMEOUT_EN
  localparam int unsigned TO = 10;
`else
  localparam int unsigned TO = 255;
`endif

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic [IW-1:0] item_data = '0;
  logic          item_valid = 1'b0;
  logic          item_ready;
  logic          flush = 1'b0;
  logic          flush_done;
  logic [WW-1:0] data;
  logic          data_valid;
  logic          read_data = 1'b0;
  item_cnt_t     num_items_per_data;
  logic          num_items_per_data_valid;
  logic [31:0]   items_emitted;

  always #5 clk = ~clk;

  result_packer #(
    .ITEM_W         (IW),
    .ITEMS_PER_WORD (NL),
    .TIMEOUT        (TO)
  ) dut (
    .clk                      (clk),
    .rstb                     (rstb),
    .item_data                (item_data),
    .item_valid               (item_valid),
    .item_ready               (item_ready),
    .flush                    (flush),
    .flush_done               (flush_done),
    .data                     (data),
    .data_valid               (data_valid),
    .read_data                (read_data),
    .num_items_per_data       (num_items_per_data),
    .num_items_per_data_valid (num_items_per_data_valid),
    .items_emitted            (items_emitted)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_word(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      for (int l = 0; l < NL; l++) begin
        if (act[l*IW +: IW] !== exp[l*IW +: IW]) begin
          $display("FAIL %s: lane %0d low bits got %0h want %0h at %0t", nm, l,
                   act[l*IW +: 64], exp[l*IW +: 64], $time);
          break;
        end
      end
    end
  endtask

  function automatic logic [IW-1:0] item(input int k);
    logic [IW-1:0] r;
    for (int i = 0; i < IW / 32; i++) r[i*32 +: 32] = 32'(k) * 32'h0100_0193 + 32'(i);
    return r;
  endfunction

  // Transaction model: items group in arrival order; a group closes at four
  // items or on a flush (including an item accepted with the flush).
  typedef struct {
    logic [WW-1:0] w;
    int            c;
  } word_t;

  word_t         expq[$];
  logic [IW-1:0] grp[$];
  logic [31:0]   sum = '0;

  function automatic void close_grp();
    word_t e;
    e.w = '0;
    e.c = grp.size();
    for (int i = 0; i < grp.size(); i++) e.w[i*IW +: IW] = grp[i];
    expq.push_back(e);
    grp.delete();
  endfunction

  always @(negedge clk) begin
    word_t e;
    if (!rstb) begin
      expq.delete();
      grp.delete();
      sum = '0;
    end else begin
      chk("items_emitted", items_emitted, sum);
      if (data_valid && read_data) begin
`ifdef RESULT_PACKER_TIMEOUT_EN
        if (expq.size() == 0 && grp.size() != 0) close_grp();
`endif
        if (expq.size() == 0) begin
          chk("unexpected word", 1, 0);
        end else begin
          e = expq.pop_front();
          chk_word("model data", data, e.w);
          chk("model count", num_items_per_data, e.c);
          sum = sum + 32'(e.c);
        end
      end
      if (item_valid && item_ready) grp.push_back(item_data);
      if (flush && grp.size() > 0) close_grp();
      if (grp.size() == NL) close_grp();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k);
    item_valid = 1'b1;
    item_data  = item(k);
    tick();
    item_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " item_ready"}, item_ready, 1);
    chk_word({tag, " data"}, data, '0);
    chk({tag, " data_valid"}, data_valid, 0);
    chk({tag, " num"}, num_items_per_data, 0);
    chk({tag, " num_valid"}, num_items_per_data_valid, 0);
    chk({tag, " flush_done"}, flush_done, 0);
    chk({tag, " items_emitted"}, items_emitted, 0);
  endtask

  task automatic do_reset();
    item_valid = 1'b0;
    flush      = 1'b0;
    read_data  = 1'b0;
    rstb       = 1'b0;
    tick();
    tick();
    rstb = 1'b1;
  endtask

  initial begin
    int acc;
    int i;
    int seen;
    logic [WW-1:0] w;

    do_reset();
    chk_reset_vals("reset");

    // Four back-to-back items, consumer always ready.
    read_data = 1'b1;
    for (int k = 1; k <= 4; k++) send(k);
    chk("t1 data_valid", data_valid, 1);
    chk("t1 num", num_items_per_data, 4);
    chk("t1 num_valid", num_items_per_data_valid, 1);
    w = {item(4), item(3), item(2), item(1)};
    chk_word("t1 data", data, w);
    tick();
    chk("t1 drained", data_valid, 0);
    chk("t1 emitted", items_emitted, 4);

    // Two items then flush.
    do_reset();
    read_data = 1'b1;
    send(5);
    send(6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t2 data_valid", data_valid, 1);
    chk("t2 num", num_items_per_data, 2);
    w = '0;
    w[IW-1:0]    = item(5);
    w[2*IW-1:IW] = item(6);
    chk_word("t2 data", data, w);
    chk("t2 no early done", flush_done, 0);
    tick();
    chk("t2 flush_done", flush_done, 1);
    tick();
    chk("t2 done single", flush_done, 0);
    chk("t2 emitted", items_emitted, 2);

    // Stalled consumer: eight items of buffering.
    do_reset();
    item_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      item_data = item(11 + acc);
      @(negedge clk);
      if (item_ready) acc++;
      tick();
    end
    chk("t3 accepted", acc, 8);
    chk("t3 ready low", item_ready, 0);
    read_data = 1'b1;
    item_data = item(19);
    tick();
    chk("t3 ready back", item_ready, 1);
    chk("t3 second word", data_valid, 1);
    chk("t3 second num", num_items_per_data, 4);
    chk("t3 second pulse", num_items_per_data_valid, 1);
    tick();
    item_data = item(20);
    tick();
    item_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();
    chk("t3 emitted", items_emitted, 10);

    // Flush together with the third item.
    do_reset();
    read_data = 1'b1;
    send(21);
    send(22);
    item_valid = 1'b1;
    item_data  = item(23);
    flush      = 1'b1;
    tick();
    item_valid = 1'b0;
    flush      = 1'b0;
    chk("t4 data_valid", data_valid, 1);
    chk("t4 num", num_items_per_data, 3);
    w = '0;
    w[3*IW-1:0] = {item(23), item(22), item(21)};
    chk_word("t4 data", data, w);
    tick();
    chk("t4 flush_done", flush_done, 1);

    // Flush with both stages empty.
    do_reset();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5 flush_done", flush_done, 1);
    chk("t5 no word", data_valid, 0);
    tick();
    chk("t5 done single", flush_done, 0);

    // One item then idle.
    do_reset();
    read_data = 1'b1;
    send(31);
    i = 0;
    seen = 0;
    while (!data_valid && i < 40) begin
      if (flush_done) seen++;
      tick();
      i++;
    end
`ifdef RESULT_PACKER_TIMEOUT_EN
    chk("t6 timeout latency ok", (i >= 10 && i <= 12), 1);
    chk("t6 num", num_items_per_data, 1);
    for (int c = 0; c < 4; c++) begin
      if (flush_done) seen++;
      tick();
    end
    chk("t6 no flush_done", seen, 0);
`else
    chk("t6 no auto word", i, 40);
`endif

    // Reset while out is valid and asm holds three items.
    do_reset();
    for (int k = 41; k <= 47; k++) send(k);
    chk("t7 out full", data_valid, 1);
    chk("t7 ready", item_ready, 1);
    rstb = 1'b0;
    #1;
    chk_reset_vals("t7 async");
    tick();
    tick();
    rstb = 1'b1;
    read_data = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (data_valid) seen++;
      tick();
    end
    chk("t7 no stale word", seen, 0);
    chk("t7 leftover model", expq.size() + grp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
